// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} arb_state_t;

    localparam int unsigned PORT_CPU = 0;
    localparam int unsigned PORT_DBG = 1;

endpackage

// File: rtl/mem_arbiter_rr_pick.sv
// Two-way round-robin pick: on a tie the port not granted last time wins.
module rr_pick2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic       valid,
    output logic       gnt
);

    always_comb begin
        valid = |req;
        gnt   = (&req) ? ~last : req[1];
    end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one exmemory between the CPU port (0) and the
// loader/debug port (1); every access is grant -> command cycle -> ack cycle.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int AWIDTH = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic              we0,
    input  logic [AWIDTH-1:0] adr0,
    input  logic [WIDTH-1:0]  wd0,
    output logic              ack0,
    output logic [WIDTH-1:0]  rd0,
    input  logic              req1,
    input  logic              we1,
    input  logic [AWIDTH-1:0] adr1,
    input  logic [WIDTH-1:0]  wd1,
    output logic              ack1,
    output logic [WIDTH-1:0]  rd1,
    output logic              memread,
    output logic              memwrite,
    output logic [AWIDTH-1:0] adr,
    output logic [WIDTH-1:0]  writedata,
    input  logic [WIDTH-1:0]  memdata
);

    arb_state_t        state;
    logic              gnt;
    logic              last;
    logic              pick_valid;
    logic              pick_gnt;
    logic              we_sel;
    logic [AWIDTH-1:0] adr_sel;
    logic [WIDTH-1:0]  wd_sel;

    rr_pick2 u_pick (
        .req   ({req1, req0}),
        .last  (last),
        .valid (pick_valid),
        .gnt   (pick_gnt)
    );

    always_comb begin
        we_sel  = pick_gnt ? we1  : we0;
        adr_sel = pick_gnt ? adr1 : adr0;
        wd_sel  = pick_gnt ? wd1  : wd0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            gnt       <= 1'b0;
            last      <= 1'b1;
            memread   <= 1'b0;
            memwrite  <= 1'b0;
            adr       <= '0;
            writedata <= '0;
            ack0      <= 1'b0;
            ack1      <= 1'b0;
            rd0       <= '0;
            rd1       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        state     <= ACCESS;
                        gnt       <= pick_gnt;
                        last      <= pick_gnt;
                        memread   <= ~we_sel;
                        memwrite  <= we_sel;
                        adr       <= adr_sel;
                        writedata <= wd_sel;
                    end
                end
                ACCESS: begin
                    // memread still holds this access's direction until this edge
                    if (memread) begin
                        if (gnt == 1'(PORT_DBG)) rd1 <= memdata;
                        else                     rd0 <= memdata;
                    end
                    memread  <= 1'b0;
                    memwrite <= 1'b0;
                    ack0     <= (gnt == 1'(PORT_CPU));
                    ack1     <= (gnt == 1'(PORT_DBG));
                    state    <= DONE;
                end
                DONE: begin
                    ack0  <= 1'b0;
                    ack1  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter with a behavioural exmemory and a
// scoreboard of expected acks checked by a negedge monitor.
module tb_mem_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic       req0, we0, ack0, req1, we1, ack1;
    logic [7:0] adr0, wd0, rd0, adr1, wd1, rd1;
    logic       memread, memwrite;
    logic [7:0] adr, writedata, memdata;
    logic [7:0] mem [256];

    typedef struct {
        int         port;
        logic       is_rd;
        logic [7:0] data;
    } sb_t;

    typedef struct {
        int         port;
        logic       we;
        logic [7:0] a;
        logic [7:0] d;
        logic [7:0] exp;
    } vec_t;

    sb_t  sbq[$];
    vec_t vecs[9];
    int   ncmp  = 0;
    int   nfail = 0;

    always #5 clk = ~clk;

    assign memdata = mem[adr];

    mem_arbiter #(.WIDTH(8), .AWIDTH(8)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .we0(we0), .adr0(adr0), .wd0(wd0), .ack0(ack0), .rd0(rd0),
        .req1(req1), .we1(we1), .adr1(adr1), .wd1(wd1), .ack1(ack1), .rd1(rd1),
        .memread(memread), .memwrite(memwrite), .adr(adr),
        .writedata(writedata), .memdata(memdata)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        ncmp++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic mem_model();
        forever begin
            @(posedge clk);
            if (memwrite) mem[adr] <= writedata;
        end
    endtask

    task automatic monitor();
        sb_t e;
        forever begin
            @(negedge clk);
            chk("mem_excl", {31'd0, memread & memwrite}, 32'd0);
            if (ack0 | ack1) begin
                chk("ack_onehot", {31'd0, ack0 & ack1}, 32'd0);
                if (sbq.size() == 0) begin
                    chk("stray_ack", {30'd0, ack1, ack0}, 32'd0);
                end else begin
                    e = sbq.pop_front();
                    chk("ack_port", ack1 ? 32'd1 : 32'd0, e.port);
                    if (e.is_rd) chk("rd_data", {24'd0, ack1 ? rd1 : rd0}, {24'd0, e.data});
                end
            end
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic access(input int p, input logic we, input logic [7:0] a,
                          input logic [7:0] d, input logic [7:0] exp);
        bit got = 0;
        sbq.push_back('{p, ~we, exp});
        if (p == 0) begin req0 = 1; we0 = we; adr0 = a; wd0 = d; end
        else        begin req1 = 1; we1 = we; adr1 = a; wd1 = d; end
        for (int cnt = 1; cnt <= 10 && !got; cnt++) begin
            @(posedge clk); #1;
            if (cnt == 1) begin
                chk("cmd_dir", {30'd0, memwrite, memread}, {30'd0, we, ~we});
                chk("cmd_adr", {24'd0, adr}, {24'd0, a});
                if (we) chk("cmd_wd", {24'd0, writedata}, {24'd0, d});
            end
            if (cnt == 2) chk("wr_one_cycle", {31'd0, memwrite}, 32'd0);
            if ((p == 0) ? ack0 : ack1) begin
                got = 1;
                chk("ack_latency", cnt, 32'd2);
            end
        end
        if (!got) chk("ack_timeout", 32'd0, 32'd1);
        req0 = 0; req1 = 0;
        @(posedge clk); #1;
    endtask

    initial begin
        int t0, t1, nack;
        reset = 1'b1;
        {req0, we0, adr0, wd0, req1, we1, adr1, wd1} = '0;
        for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'hC3;
        mem[8'h01] = 8'hA5;
        mem[8'h02] = 8'h3C;
        mem[8'h07] = 8'h77;

        vecs[0] = '{0, 1'b1, 8'h03, 8'h69, 8'h00};
        vecs[1] = '{0, 1'b0, 8'h03, 8'h00, 8'h69};
        vecs[2] = '{1, 1'b1, 8'h10, 8'h11, 8'h00};
        vecs[3] = '{1, 1'b1, 8'h11, 8'h22, 8'h00};
        vecs[4] = '{1, 1'b0, 8'h10, 8'h00, 8'h11};
        vecs[5] = '{1, 1'b0, 8'h11, 8'h00, 8'h22};
        vecs[6] = '{0, 1'b1, 8'hFF, 8'h5A, 8'h00};
        vecs[7] = '{1, 1'b0, 8'hFF, 8'h00, 8'h5A};
        vecs[8] = '{0, 1'b0, 8'h00, 8'h00, 8'hC3};

        fork
            mem_model();
            monitor();
        join_none

        repeat (2) @(posedge clk); #1;
        chk("rst_ctl", {28'd0, memread, memwrite, ack0, ack1}, 32'd0);
        chk("rst_adr", {24'd0, adr}, 32'd0);
        chk("rst_wd", {24'd0, writedata}, 32'd0);
        chk("rst_rd", {16'd0, rd0, rd1}, 32'd0);

        // tie straight out of reset: port 0 first, port 1 three cycles later
        req0 = 1; we0 = 0; adr0 = 8'h01;
        req1 = 1; we1 = 0; adr1 = 8'h02;
        sbq.push_back('{0, 1'b1, 8'hA5});
        sbq.push_back('{1, 1'b1, 8'h3C});
        reset = 1'b0;
        t0 = -1; t1 = -1;
        for (int cnt = 1; cnt <= 20 && (t0 < 0 || t1 < 0); cnt++) begin
            @(posedge clk); #1;
            if (ack0) begin t0 = cnt; req0 = 0; end
            if (ack1) begin t1 = cnt; req1 = 0; end
        end
        chk("tie_ack0_cycle", t0, 32'd2);
        chk("tie_ack1_cycle", t1, 32'd5);
        req0 = 0; req1 = 0;
        @(posedge clk); #1;

        for (int i = 0; i < 9; i++)
            access(vecs[i].port, vecs[i].we, vecs[i].a, vecs[i].d, vecs[i].exp);

        // both ports hold req for six grants: strict alternation from port 0
        do_reset();
        adr0 = 8'h20; adr1 = 8'h21; we0 = 0; we1 = 0;
        for (int i = 0; i < 6; i++)
            sbq.push_back('{i % 2, 1'b1, (i % 2 == 0) ? (8'h20 ^ 8'hC3) : (8'h21 ^ 8'hC3)});
        req0 = 1; req1 = 1;
        nack = 0;
        for (int cnt = 1; cnt <= 40 && nack < 6; cnt++) begin
            @(posedge clk); #1;
            if (ack0 | ack1) nack++;
        end
        chk("rr_ack_count", nack, 32'd6);
        req0 = 0; req1 = 0;
        @(posedge clk); #1;

        // reset landing in the ACCESS cycle of a port 0 read
        do_reset();
        req0 = 1; we0 = 0; adr0 = 8'h03;
        @(posedge clk); #1;
        chk("rst_acc_cmd", {31'd0, memread}, 32'd1);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("rst_acc_ctl", {28'd0, memread, memwrite, ack0, ack1}, 32'd0);
        chk("rst_acc_bus", {16'd0, adr, writedata}, 32'd0);
        chk("rst_acc_rd", {16'd0, rd0, rd1}, 32'd0);
        reset = 1'b0; req0 = 0;
        repeat (4) @(posedge clk); #1;
        chk("rst_acc_noack", {31'd0, ack0}, 32'd0);

        // command fields frozen at grant
        sbq.push_back('{0, 1'b1, 8'h69});
        req0 = 1; we0 = 0; adr0 = 8'h03;
        @(posedge clk); #1;
        adr0 = 8'h07;
        chk("frozen_adr", {24'd0, adr}, 32'h03);
        @(posedge clk); #1;
        chk("frozen_ack", {31'd0, ack0}, 32'd1);
        chk("frozen_rd", {24'd0, rd0}, 32'h69);
        req0 = 0;

        repeat (3) @(posedge clk); #1;
        chk("sb_drained", sbq.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
